// File: rtl/execute_pipe.sv
// EX/MEM pipeline register of the RV32I core: captures execute results, raises a
// one-cycle control-flow redirect and squashes the wrong-path entries behind it.
module execute_pipe #(
  parameter int unsigned KILL_CYCLES = 2,
  parameter int unsigned COUNT_W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_in,
  input  logic               stall,
  input  logic               flush,
  input  logic               load_in,
  input  logic               store_in,
  input  logic               next_sel_in,
  input  logic               branch_result_in,
  input  logic               reg_write_in,
  input  logic [4:0]         rd_in,
  input  logic [1:0]         mem_to_reg_in,
  input  logic [31:0]        alu_result_in,
  input  logic [31:0]        opb_data_in,
  input  logic [31:0]        pc_plus4_in,
  output logic               valid_out,
  output logic               load,
  output logic               store,
  output logic               reg_write,
  output logic [4:0]         rd_out,
  output logic [1:0]         mem_to_reg,
  output logic [31:0]        alu_result_out,
  output logic [31:0]        opb_data_out,
  output logic [31:0]        pc_plus4_out,
  output logic               redirect,
  output logic [31:0]        redirect_target,
  output logic               squashing,
  output logic               fwd_valid,
  output logic               fwd_is_load,
  output logic [31:0]        fwd_data,
  output logic [COUNT_W-1:0] inst_count
);

  localparam int unsigned KCNT_W = 3;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_KILL = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [KCNT_W-1:0] kcnt_q, kcnt_d;
  logic              squash;
  logic              acc;
  logic              taken;

  // Entry acceptance: anything arriving inside the kill window becomes a bubble.
  always_comb begin
    squash = (state_q == S_KILL);
    acc    = valid_in & ~squash;
    taken  = acc & (next_sel_in | branch_result_in);
  end

  // Kill-window FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      kcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      kcnt_q  <= kcnt_d;
    end
  end

  // Next state: only captured (non-stalled) edges consume kill slots.
  always_comb begin
    state_d = state_q;
    kcnt_d  = kcnt_q;
    if (flush) begin
      state_d = S_IDLE;
      kcnt_d  = '0;
    end else if (!stall) begin
      case (state_q)
        S_IDLE: begin
          if (taken) begin
            state_d = S_KILL;
            kcnt_d  = KCNT_W'(KILL_CYCLES);
          end
        end
        S_KILL: begin
          kcnt_d = kcnt_q - KCNT_W'(1);
          if (kcnt_q <= KCNT_W'(1)) begin
            state_d = S_IDLE;
            kcnt_d  = '0;
          end
        end
        default: begin
          state_d = S_IDLE;
          kcnt_d  = '0;
        end
      endcase
    end
  end

  // EX/MEM payload, redirect pulse and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out       <= 1'b0;
      load            <= 1'b0;
      store           <= 1'b0;
      reg_write       <= 1'b0;
      rd_out          <= '0;
      mem_to_reg      <= '0;
      alu_result_out  <= '0;
      opb_data_out    <= '0;
      pc_plus4_out    <= '0;
      redirect        <= 1'b0;
      redirect_target <= '0;
      inst_count      <= '0;
    end else if (flush) begin
      valid_out <= 1'b0;
      load      <= 1'b0;
      store     <= 1'b0;
      reg_write <= 1'b0;
      redirect  <= 1'b0;
    end else if (stall) begin
      // Holding everything except the pulse keeps the redirect from repeating.
      redirect <= 1'b0;
    end else begin
      valid_out      <= acc;
      load           <= load_in & acc;
      store          <= store_in & acc;
      reg_write      <= reg_write_in & acc;
      rd_out         <= rd_in;
      mem_to_reg     <= mem_to_reg_in;
      alu_result_out <= alu_result_in;
      opb_data_out   <= opb_data_in;
      pc_plus4_out   <= pc_plus4_in;
      redirect       <= taken;
      if (taken) begin
        redirect_target <= alu_result_in;
      end
      inst_count <= inst_count + COUNT_W'(acc);
    end
  end

  // Forwarding view of the registered entry.
  always_comb begin
    squashing   = (state_q == S_KILL);
    fwd_valid   = valid_out & reg_write & (rd_out != 5'd0);
    fwd_is_load = fwd_valid & load;
    fwd_data    = alu_result_out;
  end

endmodule

// File: tb/tb_execute_pipe.sv
// Bench for execute_pipe: randomized and directed stimulus against a countdown-based
// reference model, plus literal expectations for the documented scenarios.
module tb_execute_pipe;

  localparam int unsigned KC = 2;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst, valid_in, stall, flush, load_in, store_in, next_sel_in;
  logic          branch_result_in, reg_write_in;
  logic [4:0]    rd_in;
  logic [1:0]    mem_to_reg_in;
  logic [31:0]   alu_result_in, opb_data_in, pc_plus4_in;
  logic          valid_out, load, store, reg_write, redirect, squashing;
  logic          fwd_valid, fwd_is_load;
  logic [4:0]    rd_out;
  logic [1:0]    mem_to_reg;
  logic [31:0]   alu_result_out, opb_data_out, pc_plus4_out, redirect_target, fwd_data;
  logic [CW-1:0] inst_count;

  int n_checks = 0;
  int n_fail   = 0;

  execute_pipe #(.KILL_CYCLES(KC), .COUNT_W(CW)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .stall(stall), .flush(flush),
    .load_in(load_in), .store_in(store_in), .next_sel_in(next_sel_in),
    .branch_result_in(branch_result_in), .reg_write_in(reg_write_in), .rd_in(rd_in),
    .mem_to_reg_in(mem_to_reg_in), .alu_result_in(alu_result_in),
    .opb_data_in(opb_data_in), .pc_plus4_in(pc_plus4_in), .valid_out(valid_out),
    .load(load), .store(store), .reg_write(reg_write), .rd_out(rd_out),
    .mem_to_reg(mem_to_reg), .alu_result_out(alu_result_out),
    .opb_data_out(opb_data_out), .pc_plus4_out(pc_plus4_out), .redirect(redirect),
    .redirect_target(redirect_target), .squashing(squashing), .fwd_valid(fwd_valid),
    .fwd_is_load(fwd_is_load), .fwd_data(fwd_data), .inst_count(inst_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: kill window as a plain "entries left to squash" count.
  bit        m_valid, m_load, m_store, m_rw, m_redir;
  bit [4:0]  m_rd;
  bit [1:0]  m_m2r;
  bit [31:0] m_alu, m_opb, m_pc4, m_tgt;
  int        kill_left = 0;
  int        m_cnt     = 0;

  task automatic model_step();
    bit sq, ac, tk;
    if (rst) begin
      {m_valid, m_load, m_store, m_rw, m_redir} = '0;
      m_rd = '0; m_m2r = '0; m_alu = '0; m_opb = '0; m_pc4 = '0; m_tgt = '0;
      kill_left = 0; m_cnt = 0;
    end else if (flush) begin
      {m_valid, m_load, m_store, m_rw, m_redir} = '0;
      kill_left = 0;
    end else if (stall) begin
      m_redir = 1'b0;
    end else begin
      sq = (kill_left > 0);
      ac = valid_in && !sq;
      tk = ac && (next_sel_in || branch_result_in);
      m_valid = ac;
      m_load  = load_in && ac;
      m_store = store_in && ac;
      m_rw    = reg_write_in && ac;
      m_rd = rd_in; m_m2r = mem_to_reg_in;
      m_alu = alu_result_in; m_opb = opb_data_in; m_pc4 = pc_plus4_in;
      m_redir = tk;
      if (tk) m_tgt = alu_result_in;
      if (sq) kill_left--;
      else if (tk) kill_left = KC;
      m_cnt = (m_cnt + int'(ac)) % (1 << CW);
    end
  endtask

  task automatic compare_all();
    bit fv;
    fv = m_valid && m_rw && (m_rd != 0);
    chk("valid_out", 32'(valid_out), 32'(m_valid));
    chk("load", 32'(load), 32'(m_load));
    chk("store", 32'(store), 32'(m_store));
    chk("reg_write", 32'(reg_write), 32'(m_rw));
    chk("rd_out", 32'(rd_out), 32'(m_rd));
    chk("mem_to_reg", 32'(mem_to_reg), 32'(m_m2r));
    chk("alu_result_out", alu_result_out, m_alu);
    chk("opb_data_out", opb_data_out, m_opb);
    chk("pc_plus4_out", pc_plus4_out, m_pc4);
    chk("redirect", 32'(redirect), 32'(m_redir));
    chk("redirect_target", redirect_target, m_tgt);
    chk("squashing", 32'(squashing), 32'(kill_left > 0));
    chk("fwd_valid", 32'(fwd_valid), 32'(fv));
    chk("fwd_is_load", 32'(fwd_is_load), 32'(fv && m_load));
    chk("fwd_data", fwd_data, m_alu);
    chk("inst_count", 32'(inst_count), 32'(m_cnt));
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    compare_all();
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    {stall, flush, load_in, store_in, next_sel_in, branch_result_in, reg_write_in} = '0;
    valid_in = 1'b0; rd_in = '0; mem_to_reg_in = '0;
    alu_result_in = '0; opb_data_in = '0; pc_plus4_in = '0;
  endtask

  task automatic plain(input logic [31:0] alu);
    idle_inputs();
    valid_in = 1'b1; alu_result_in = alu;
  endtask

  initial begin
    rst = 1'b1;
    valid_in = 1'b1; stall = 1'b0; flush = 1'b0; load_in = 1'b1; store_in = 1'b1;
    next_sel_in = 1'b1; branch_result_in = 1'b1; reg_write_in = 1'b1; rd_in = 5'd7;
    mem_to_reg_in = 2'd3; alu_result_in = 32'hdead_beef; opb_data_in = 32'h1234_5678;
    pc_plus4_in = 32'h0000_0044;
    cyc(); cyc();
    chk("rst valid_out", 32'(valid_out), 32'd0);
    chk("rst alu_result_out", alu_result_out, 32'd0);
    chk("rst redirect", 32'(redirect), 32'd0);
    chk("rst inst_count", 32'(inst_count), 32'd0);

    rst = 1'b0; plain(32'h10);
    cyc();
    chk("first valid_out", 32'(valid_out), 32'd1);
    chk("first alu_result_out", alu_result_out, 32'h10);
    chk("first inst_count", 32'(inst_count), 32'd1);

    // Taken branch then two squashed entries
    plain(32'h100); branch_result_in = 1'b1; reg_write_in = 1'b1; rd_in = 5'd3;
    cyc();
    chk("br redirect", 32'(redirect), 32'd1);
    chk("br target", redirect_target, 32'h100);
    chk("br squashing", 32'(squashing), 32'd1);
    chk("br inst_count", 32'(inst_count), 32'd2);
    plain(32'h200); reg_write_in = 1'b1; rd_in = 5'd4;
    cyc();
    chk("sq1 valid_out", 32'(valid_out), 32'd0);
    chk("sq1 reg_write", 32'(reg_write), 32'd0);
    chk("sq1 redirect", 32'(redirect), 32'd0);
    cyc();
    chk("sq2 valid_out", 32'(valid_out), 32'd0);
    chk("sq2 squashing", 32'(squashing), 32'd0);
    cyc();
    chk("post valid_out", 32'(valid_out), 32'd1);
    chk("post inst_count", 32'(inst_count), 32'd3);

    // Jump then stall inside the kill window
    plain(32'h400); next_sel_in = 1'b1;
    cyc();
    chk("jmp redirect", 32'(redirect), 32'd1);
    plain(32'h500); stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall redirect", 32'(redirect), 32'd0);
      chk("stall squashing", 32'(squashing), 32'd1);
      chk("stall alu_result_out", alu_result_out, 32'h400);
      chk("stall valid_out", 32'(valid_out), 32'd1);
    end
    stall = 1'b0;
    cyc(); chk("stall sq1 valid_out", 32'(valid_out), 32'd0);
    cyc(); chk("stall sq2 valid_out", 32'(valid_out), 32'd0);
    cyc();
    chk("stall post valid_out", 32'(valid_out), 32'd1);
    chk("stall post inst_count", 32'(inst_count), 32'd5);

    // Flush right after a taken branch
    plain(32'h600); branch_result_in = 1'b1;
    cyc();
    plain(32'h700); flush = 1'b1;
    cyc();
    chk("flush valid_out", 32'(valid_out), 32'd0);
    chk("flush redirect", 32'(redirect), 32'd0);
    chk("flush squashing", 32'(squashing), 32'd0);
    plain(32'h800);
    cyc();
    chk("after flush valid_out", 32'(valid_out), 32'd1);
    chk("after flush inst_count", 32'(inst_count), 32'd7);

    // Forwarding
    plain(32'h900); reg_write_in = 1'b1; rd_in = 5'd0;
    cyc();
    chk("fwd x0 fwd_valid", 32'(fwd_valid), 32'd0);
    plain(32'ha00); reg_write_in = 1'b1; rd_in = 5'd5; load_in = 1'b1;
    cyc();
    chk("fwd ld fwd_valid", 32'(fwd_valid), 32'd1);
    chk("fwd ld fwd_is_load", 32'(fwd_is_load), 32'd1);
    chk("fwd ld fwd_data", fwd_data, 32'ha00);

    // Counter wrap at COUNT_W=4
    idle_inputs(); rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      plain(32'(i));
      cyc();
    end
    chk("wrap inst_count", 32'(inst_count), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst              = ($urandom_range(0, 199) == 0);
      flush            = ($urandom_range(0, 29) == 0);
      stall            = ($urandom_range(0, 4) == 0);
      valid_in         = ($urandom_range(0, 9) < 8);
      branch_result_in = ($urandom_range(0, 7) == 0);
      next_sel_in      = ($urandom_range(0, 11) == 0);
      load_in          = 1'($urandom);
      store_in         = 1'($urandom);
      reg_write_in     = 1'($urandom);
      rd_in            = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      mem_to_reg_in    = 2'($urandom);
      alu_result_in    = $urandom;
      opb_data_in      = $urandom;
      pc_plus4_in      = $urandom;
      cyc();
    end

    idle_inputs(); rst = 1'b0;
    cyc(); cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/execute_pipe.md
Name: execute_pipe

Overview:
- EX/MEM pipeline register of the RV32I pipelined core. It consumes the execute-stage results of the instruction held in the ID/EX register and feeds the memory/writeback stages.
- Owns control-flow redirect: a taken branch or jump resolved in EX produces a one-cycle redirect pulse. It then squashes the wrong-path instructions that arrive behind it for KILL_CYCLES accepted cycles.
- Provides EX/MEM forwarding outputs and a retired-instruction counter.

Parameters:
KILL_CYCLES, 2, number of accepted (non-stalled) cycles after a taken redirect during which incoming entries become bubbles; legal range 1..7
COUNT_W, 32, width of the accepted-instruction counter

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
valid_in  in  1  ID/EX entry holds a real instruction
stall  in  1  hold EX/MEM contents (memory stage busy)
flush  in  1  external kill of this stage (trap/exception)
load_in  in  1  instruction is a load
store_in  in  1  instruction is a store
next_sel_in  in  1  jump (jal/jalr)
branch_result_in  in  1  branch condition true
reg_write_in  in  1  instruction writes rd
rd_in  in  5  destination register
mem_to_reg_in  in  2  writeback select
alu_result_in  in  32  ALU result / effective address / jump target
opb_data_in  in  32  store data
pc_plus4_in  in  32  link value
valid_out  out  1  EX/MEM entry valid
load  out  1  registered load, gated by valid
store  out  1  registered store, gated by valid
reg_write  out  1  registered reg_write, gated by valid
rd_out  out  5  registered rd
mem_to_reg  out  2  registered writeback select
alu_result_out  out  32  registered ALU result
opb_data_out  out  32  registered store data
pc_plus4_out  out  32  registered link value
redirect  out  1  one-cycle pulse: taken control transfer
redirect_target  out  32  target PC, valid while redirect=1
squashing  out  1  kill window active (state KILL)
fwd_valid  out  1  valid_out & reg_write & (rd_out!=0)
fwd_is_load  out  1  forwarded entry is a load (consumer must stall)
fwd_data  out  32  equals alu_result_out
inst_count  out  COUNT_W  accepted valid instructions, wraps

Behaviour:
- Interface: single clock clk; rst is synchronous and active-high.
- Reset: all outputs 0, state IDLE, kill counter 0, inst_count 0.
- Update priority each rising edge: rst > flush > stall > capture.
- flush:
  - valid_out, load, store, reg_write and redirect are cleared to 0.
  - Data registers hold their values.
  - State returns to IDLE and the kill counter is cleared.
- stall:
  - All registers, state, counter and inst_count hold.
  - redirect is forced to 0 after a stalled edge, so the pulse is never repeated.
- capture (no rst/flush/stall):
  - squash = (state==KILL).
  - acc = valid_in & ~squash.
  - valid_out <= acc.
  - load, store, reg_write <= their inputs ANDed with acc.
  - All data fields capture their inputs.
  - inst_count increments by 1 if acc, modulo 2^COUNT_W.
  - taken = acc & (next_sel_in | branch_result_in).
  - redirect <= taken; redirect_target <= alu_result_in when taken.
- FSM:
  - IDLE: if taken, go to KILL with counter = KILL_CYCLES.
  - KILL: squashing=1. Each captured edge decrements the counter. Reaching 0 returns to IDLE, on the edge that consumes the last kill slot. Branches arriving while squashed are ignored.
- Latency: one cycle from input to EX/MEM outputs.
  - redirect asserts in the cycle after taken capture.
  - squashing asserts in that same cycle.
- Forwarding outputs are purely combinational from the registered state.

Test Plan:
- Reset: rst=1 for 2 cycles with valid_in=1 and all inputs nonzero -> all outputs 0, inst_count=0. Releasing rst with valid_in=1, alu_result_in=32'h10 -> after 1 edge valid_out=1, alu_result_out=32'h10, inst_count=1.
- Taken branch: valid_in=1, branch_result_in=1, alu_result_in=32'h0000_0100 -> next cycle redirect=1, redirect_target=32'h100, squashing=1. The next 2 valid_in=1 entries produce valid_out=0 and reg_write=0. The third entry produces valid_out=1. inst_count advances by 1 for the branch, not for the squashed entries.
- Stall during kill window: taken jump (next_sel_in=1), then stall=1 for 3 cycles -> outputs hold, redirect is 1 only for the first cycle, squashing stays 1. After stall drops, 2 more bubbles, then normal capture.
- Flush mid-kill: taken branch, then flush=1 on the next edge -> valid_out=0, redirect=0, squashing=0. The following valid_in=1 entry is captured as valid.
- Forwarding: reg_write_in=1, rd_in=0 -> fwd_valid=0. With rd_in=5, load_in=1 -> fwd_valid=1, fwd_is_load=1, fwd_data=alu_result_out.
- Counter wrap: COUNT_W=4, 17 accepted valid instructions -> inst_count=1.
